// File: rtl/change_dispenser_pkg.sv
// Shared coin values, FSM states and coin-select encoding for the change dispenser.
// Also used by the vending-machine controller and the benches.
package change_dispenser_pkg;

  localparam int unsigned COIN_Q = 5;
  localparam int unsigned COIN_D = 2;
  localparam int unsigned COIN_N = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One-hot solenoid select {quarter, dime, nickel}
  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_N    = 3'b001,
    SEL_D    = 3'b010,
    SEL_Q    = 3'b100
  } coin_sel_e;

  function automatic int unsigned coin_value(input coin_sel_e sel);
    case (sel)
      SEL_Q:   coin_value = COIN_Q;
      SEL_D:   coin_value = COIN_D;
      SEL_N:   coin_value = COIN_N;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter with zero flag; times both the pulse and the gap phases.
module change_dispenser_pulse_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: steers one timed pulse at a time to the quarter/dime/nickel solenoid.
// Optional per-transaction coin tally outputs under `define CHANGE_DISP_TALLY_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             disp_q,
  output logic             disp_d,
  output logic             disp_n
`ifdef CHANGE_DISP_TALLY_EN
  ,
  output logic [AMT_W-1:0] q_cnt,
  output logic [AMT_W-1:0] d_cnt,
  output logic [AMT_W-1:0] n_cnt
`endif
);

  localparam int unsigned TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  coin_sel_e        sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  coin_sel_e        coin_c;
  logic             tmr_load_c;
  logic             tmr_dec_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic             tmr_zero_c;

  change_dispenser_pulse_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .dec      (tmr_dec_c),
    .load_val (tmr_val_c),
    .zero_c   (tmr_zero_c)
  );

  // Greedy pick from what is still owed
  always_comb begin
    coin_c = SEL_NONE;
    if (rem_q >= AMT_W'(COIN_Q)) begin
      coin_c = SEL_Q;
    end else if (rem_q >= AMT_W'(COIN_D)) begin
      coin_c = SEL_D;
    end else if (rem_q != '0) begin
      coin_c = SEL_N;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;
    tmr_val_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = amount;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          sel_d      = coin_c;
          rem_d      = rem_q - AMT_W'(coin_value(coin_c));
          tmr_load_c = 1'b1;
          tmr_val_c  = TMR_W'(PULSE_LEN - 1);
          state_d    = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero_c) begin
          sel_d      = SEL_NONE;
          tmr_load_c = 1'b1;
          tmr_val_c  = TMR_W'(GAP_LEN - 1);
          state_d    = ST_GAP;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero_c) begin
          state_d = ST_SELECT;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sel_q   <= SEL_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign disp_q = (sel_q == SEL_Q);
  assign disp_d = (sel_q == SEL_D);
  assign disp_n = (sel_q == SEL_N);

`ifdef CHANGE_DISP_TALLY_EN
  logic [AMT_W-1:0] q_cnt_q, q_cnt_d;
  logic [AMT_W-1:0] d_cnt_q, d_cnt_d;
  logic [AMT_W-1:0] n_cnt_q, n_cnt_d;

  // Count lands together with the pulse rising, so it is visible in the first pulse cycle
  always_comb begin
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      q_cnt_d = '0;
      d_cnt_d = '0;
      n_cnt_d = '0;
    end else if ((state_q == ST_SELECT) && (rem_q != '0)) begin
      case (coin_c)
        SEL_Q:   q_cnt_d = q_cnt_q + AMT_W'(1);
        SEL_D:   d_cnt_d = d_cnt_q + AMT_W'(1);
        SEL_N:   n_cnt_d = n_cnt_q + AMT_W'(1);
        default: q_cnt_d = q_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_cnt_q <= '0;
      d_cnt_q <= '0;
      n_cnt_q <= '0;
    end else begin
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
    end
  end

  assign q_cnt = q_cnt_q;
  assign d_cnt = d_cnt_q;
  assign n_cnt = n_cnt_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random amounts against a cycle-timeline model.
// Two instances: default timing (A) and PULSE_LEN=1/GAP_LEN=3 (B).
module tb_change_dispenser;

  localparam int unsigned AMT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic             start_a = 1'b0, start_b = 1'b0;
  logic [AMT_W-1:0] amount_a = '0, amount_b = '0;
  logic busy_a, done_a, dq_a, dd_a, dn_a;
  logic busy_b, done_b, dq_b, dd_b, dn_b;
`ifdef CHANGE_DISP_TALLY_EN
  logic [AMT_W-1:0] qc_a, dc_a, nc_a, qc_b, dc_b, nc_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_LEN(2), .GAP_LEN(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .amount(amount_a),
    .busy(busy_a), .done(done_a), .disp_q(dq_a), .disp_d(dd_a), .disp_n(dn_a)
`ifdef CHANGE_DISP_TALLY_EN
    , .q_cnt(qc_a), .d_cnt(dc_a), .n_cnt(nc_a)
`endif
  );

  change_dispenser #(.AMT_W(AMT_W), .PULSE_LEN(1), .GAP_LEN(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .amount(amount_b),
    .busy(busy_b), .done(done_b), .disp_q(dq_b), .disp_d(dd_b), .disp_n(dn_b)
`ifdef CHANGE_DISP_TALLY_EN
    , .q_cnt(qc_b), .d_cnt(dc_b), .n_cnt(nc_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one transaction and check every cycle against a timeline built from the greedy rule.
  // mode 0: quiet start; 1: random start/amount noise while busy; 2: re-request amount=10 in PULSE and DONE.
  task automatic run_txn(input bit use_b, input int amt, input int pl, input int gl,
                         input int mode, input string tag);
    int nq, nd, nn, ncoin, len, t_done, k, off;
    logic [2:0] exp_disp, obs_disp;
    logic obs_busy, obs_done;
    nq     = amt / 5;
    nd     = (amt % 5) / 2;
    nn     = (amt % 5) % 2;
    ncoin  = nq + nd + nn;
    len    = 1 + pl + gl;
    t_done = 2 + ncoin * len;

    @(negedge clk);
    if (use_b) begin start_b = 1'b1; amount_b = AMT_W'(amt); end
    else       begin start_a = 1'b1; amount_a = AMT_W'(amt); end
    @(posedge clk);
    #1;
    if (use_b) start_b = 1'b0; else start_a = 1'b0;

    for (int c = 1; c <= t_done + 1; c++) begin
      @(negedge clk);
      exp_disp = 3'b000;
      if (c >= 2 && c < t_done) begin
        k   = (c - 2) / len;
        off = (c - 2) % len;
        if (off < pl) exp_disp = (k < nq) ? 3'b100 : (k < nq + nd) ? 3'b010 : 3'b001;
      end
      obs_busy = use_b ? busy_b : busy_a;
      obs_done = use_b ? done_b : done_a;
      obs_disp = use_b ? {dq_b, dd_b, dn_b} : {dq_a, dd_a, dn_a};
      chk($sformatf("%s amt%0d c%0d busy", tag, amt, c), 32'(obs_busy), 32'(c <= t_done));
      chk($sformatf("%s amt%0d c%0d done", tag, amt, c), 32'(obs_done), 32'(c == t_done));
      chk($sformatf("%s amt%0d c%0d disp", tag, amt, c), 32'(obs_disp), 32'(exp_disp));
      chk($sformatf("%s amt%0d c%0d onehot0", tag, amt, c), 32'($countones(obs_disp) <= 1), 32'd1);
`ifdef CHANGE_DISP_TALLY_EN
      if (c == t_done + 1) begin
        chk($sformatf("%s amt%0d q_cnt", tag, amt), 32'(use_b ? qc_b : qc_a), 32'(nq));
        chk($sformatf("%s amt%0d d_cnt", tag, amt), 32'(use_b ? dc_b : dc_a), 32'(nd));
        chk($sformatf("%s amt%0d n_cnt", tag, amt), 32'(use_b ? nc_b : nc_a), 32'(nn));
      end
`endif
      // Any start raised here is sampled at the end of cycle c, when the DUT must ignore it
      if (mode == 1) begin
        if (c <= t_done) begin
          if (use_b) begin start_b = 1'($urandom); amount_b = AMT_W'($urandom); end
          else       begin start_a = 1'($urandom); amount_a = AMT_W'($urandom); end
        end else begin
          if (use_b) start_b = 1'b0; else start_a = 1'b0;
        end
      end else if (mode == 2) begin
        if (c == 2 || c == t_done) begin start_a = 1'b1; amount_a = AMT_W'(10); end
        if (c == 4 || c == t_done + 1) start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset disp", 32'({dq_a, dd_a, dn_a}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset busy", 32'(busy_a), 32'd0);
`ifdef CHANGE_DISP_TALLY_EN
    chk("reset q_cnt", 32'(qc_a), 32'd0);
`endif

    run_txn(1'b0, 0, 2, 1, 0, "zero");
    run_txn(1'b0, 8, 2, 1, 0, "eight");
    run_txn(1'b0, 63, 2, 1, 0, "max");
    run_txn(1'b0, 5, 2, 1, 2, "restart_ignored");
    @(negedge clk);
    chk("idle after ignored restart", 32'(busy_a), 32'd0);

    // Asynchronous abort in the middle of a dime pulse
    @(negedge clk);
    start_a  = 1'b1;
    amount_a = AMT_W'(4);
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort pre disp_d", 32'({dq_a, dd_a, dn_a}), 32'b010);
    #1 rst = 1'b1;
    #1;
    chk("abort disp async", 32'({dq_a, dd_a, dn_a}), 32'b000);
    chk("abort busy async", 32'(busy_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort quiet c%0d", i), 32'({busy_a, done_a, dq_a, dd_a, dn_a}), 32'd0);
    end
    run_txn(1'b0, 8, 2, 1, 0, "after_abort");

    run_txn(1'b1, 1, 1, 3, 0, "long_gap");

    for (int i = 0; i < 12; i++) begin
      run_txn(1'b0, int'($urandom_range(63, 0)), 2, 1, 1, "rand_a");
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, int'($urandom_range(63, 0)), 1, 3, 1, "rand_b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
